// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the word-to-byte memory bridge.
package mem_bridge_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } bridge_state_t;

endpackage

// File: rtl/byte_lane_assembler.sv
// Four byte-wide lane registers with clear, lane-selected capture and a word view.
// The word output already includes the byte being captured this cycle.
module byte_lane_assembler
  import mem_bridge_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clr,
  input  logic                             cap_en,
  input  logic [1:0]                       lane_sel,
  input  logic [BYTE_W-1:0]                byte_in,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] word
);

  logic [BYTE_W-1:0] lane_q [BYTES_PER_WORD];
  logic [BYTE_W-1:0] lane_d [BYTES_PER_WORD];

  always_comb begin
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      lane_d[i] = clr ? '0 : lane_q[i];
    end
    if (cap_en) begin
      lane_d[lane_sel] = byte_in;
    end
  end

  // Exposing the next value lets the last byte land in the word on the same edge.
  always_comb begin
    word = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      word[i*BYTE_W +: BYTE_W] = lane_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        lane_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

endmodule

// File: rtl/mem_word_bridge.sv
// Sequential bridge: 32-bit word reads/writes to a byte-wide memory with a registered read port.
// All memory-side outputs decode from registered state only.
module mem_word_bridge
  import mem_bridge_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_read,
  input  logic                             req_write,
  input  logic [WIDTH-1:0]                 word_adr,
  input  logic [BYTES_PER_WORD*BYTE_W-1:0] wdata,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] rdata,
  output logic                             done,
  output logic                             busy,
  output logic                             memread,
  output logic                             memwrite,
  output logic [WIDTH-1:0]                 adr,
  output logic [BYTE_W-1:0]                writedata,
  input  logic [BYTE_W-1:0]                memdata
);

  localparam int WORD_W = BYTES_PER_WORD * BYTE_W;

  bridge_state_t     state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [WIDTH-1:2]  base_q, base_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              asm_clr;
  logic              asm_cap;
  logic [1:0]        asm_lane;
  logic [WORD_W-1:0] asm_word;

  // The two low address bits select nothing: words are always aligned.
  logic unused_adr_bits;
  assign unused_adr_bits = ^word_adr[1:0];

  byte_lane_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clr      (asm_clr),
    .cap_en   (asm_cap),
    .lane_sel (asm_lane),
    .byte_in  (memdata),
    .word     (asm_word)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    asm_clr  = 1'b0;
    asm_cap  = 1'b0;
    asm_lane = k_q - 2'd1;
    unique case (state_q)
      IDLE: begin
        if (req_read) begin
          base_d  = word_adr[WIDTH-1:2];
          k_d     = 2'd0;
          asm_clr = 1'b1;
          state_d = READ;
        end else if (req_write) begin
          base_d  = word_adr[WIDTH-1:2];
          wdata_d = wdata;
          k_d     = 2'd0;
          state_d = WRITE;
        end
      end
      READ: begin
        // Read data trails the strobe by one cycle, so byte k-1 arrives now.
        asm_cap = (k_q != 2'd0);
        k_d     = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        asm_cap  = 1'b1;
        asm_lane = 2'd3;
        rdata_d  = asm_word;
        state_d  = DONE;
      end
      WRITE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    memread   = (state_q == READ);
    memwrite  = (state_q == WRITE);
    done      = (state_q == DONE);
    busy      = (state_q != IDLE);
    adr       = (memread || memwrite) ? {base_q, k_q} : '0;
    writedata = memwrite ? wdata_q[{k_q, 3'b000} +: BYTE_W] : '0;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_mem_word_bridge.sv
// Directed and randomized word read/write traffic against a byte-memory model and a word-level reference.
module tb_mem_word_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write;
  logic [7:0]  word_adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done, busy, memread, memwrite;
  logic [7:0]  adr, writedata, memdata;

  logic        preload;
  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] last_rd;
  int          checks   = 0;
  int          failures = 0;

  mem_word_bridge #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_read  (req_read),
    .req_write (req_write),
    .word_adr  (word_adr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .busy      (busy),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .memdata   (memdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] dead;
    dead = 32'hDEADBEEF;
    if (i >= 4 && i <= 7) return dead[(i-4)*8 +: 8];
    return 8'(i) ^ 8'h5A;
  endfunction

  // Byte memory with registered read port.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (memwrite) begin
      mem[adr] <= writedata;
    end
    if (memread) memdata <= mem[adr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = a & 8'hFC;
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  task automatic do_read(input logic [7:0] a, input bit hold_w);
    logic [7:0]  b;
    logic [31:0] exp;
    b   = a & 8'hFC;
    exp = ref_word(a);
    req_read  = 1'b1;
    req_write = hold_w;
    word_adr  = a;
    step();
    for (int k = 0; k < 4; k++) begin
      req_read = 1'($urandom_range(0, 1));
      word_adr = 8'($urandom);
      if (!hold_w) begin
        req_write = 1'($urandom_range(0, 1));
        wdata     = $urandom;
      end
      chk("rd_memread", 32'(memread), 32'd1);
      chk("rd_memwrite", 32'(memwrite), 32'd0);
      chk("rd_adr", 32'(adr), 32'(b + 8'(k)));
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_done_early", 32'(done), 32'd0);
      step();
    end
    chk("drain_memread", 32'(memread), 32'd0);
    chk("drain_memwrite", 32'(memwrite), 32'd0);
    chk("drain_done", 32'(done), 32'd0);
    chk("drain_rdata_held", rdata, last_rd);
    step();
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_busy_done", 32'(busy), 32'd1);
    chk("rd_rdata", rdata, exp);
    chk("rd_memwrite_done", 32'(memwrite), 32'd0);
    req_read  = 1'b0;
    req_write = hold_w;
    step();
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_idle_done", 32'(done), 32'd0);
    chk("rd_idle_memwrite", 32'(memwrite), 32'd0);
    chk("rd_idle_rdata", rdata, exp);
    last_rd = exp;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] b;
    b = a & 8'hFC;
    req_write = 1'b1;
    req_read  = 1'b0;
    word_adr  = a;
    wdata     = d;
    step();
    for (int k = 0; k < 4; k++) begin
      req_read  = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      word_adr  = 8'($urandom);
      wdata     = $urandom;
      chk("wr_memwrite", 32'(memwrite), 32'd1);
      chk("wr_memread", 32'(memread), 32'd0);
      chk("wr_adr", 32'(adr), 32'(b + 8'(k)));
      chk("wr_byte", 32'(writedata), 32'(d[k*8 +: 8]));
      chk("wr_busy", 32'(busy), 32'd1);
      step();
    end
    req_read  = 1'b0;
    req_write = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_memwrite_done", 32'(memwrite), 32'd0);
    chk("wr_busy_done", 32'(busy), 32'd1);
    chk("wr_rdata_held", rdata, last_rd);
    step();
    chk("wr_idle_busy", 32'(busy), 32'd0);
    chk("wr_idle_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      ref_mem[b + 8'(k)] = d[k*8 +: 8];
      chk("wr_mem_byte", 32'(mem[b + 8'(k)]), 32'(ref_mem[b + 8'(k)]));
    end
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    req_read = 1'b0; req_write = 1'b0; word_adr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    last_rd = '0;
    step(); step();
    preload = 1'b0;
    chk("rst_memread", 32'(memread), 32'd0);
    chk("rst_memwrite", 32'(memwrite), 32'd0);
    chk("rst_adr", 32'(adr), 32'd0);
    chk("rst_writedata", 32'(writedata), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    do_read(8'h04, 1'b0);
    chk("deadbeef", last_rd, 32'hDEADBEEF);

    do_write(8'h08, 32'h11223344);
    chk("byte08", 32'(mem[8'h08]), 32'h44);
    chk("byte0B", 32'(mem[8'h0B]), 32'h11);
    do_read(8'h08, 1'b0);
    chk("readback", last_rd, 32'h11223344);
    do_read(8'h0B, 1'b0);
    chk("unaligned", last_rd, 32'h11223344);

    // Both requests together: read wins, held write only starts once IDLE.
    wdata = 32'hCAFEF00D;
    do_read(8'h04, 1'b1);
    chk("conflict_data", last_rd, 32'hDEADBEEF);
    do_write(8'h10, 32'hCAFEF00D);

    // Reset during a read.
    req_read = 1'b1; word_adr = 8'h04;
    step();
    req_read = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rrst_memread", 32'(memread), 32'd0);
    chk("rrst_adr", 32'(adr), 32'd0);
    chk("rrst_busy", 32'(busy), 32'd0);
    chk("rrst_rdata", rdata, 32'd0);
    chk("rrst_done", 32'(done), 32'd0);
    last_rd = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rrst_no_done", 32'(done), 32'd0);
      chk("rrst_idle", 32'(busy), 32'd0);
    end
    do_read(8'h04, 1'b0);
    chk("post_rst_read", last_rd, 32'hDEADBEEF);

    // Reset during a write: only the first two bytes reach memory.
    req_write = 1'b1; word_adr = 8'h0C; wdata = 32'hAABBCCDD;
    step();
    req_write = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wrst_memwrite", 32'(memwrite), 32'd0);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_writedata", 32'(writedata), 32'd0);
    step();
    chk("wrst_memwrite2", 32'(memwrite), 32'd0);
    ref_mem[8'h0C] = 8'hDD;
    ref_mem[8'h0D] = 8'hCC;
    for (int i = 12; i < 16; i++) chk("wrst_mem", 32'(mem[i]), 32'(ref_mem[i]));
    chk("wrst_0E_untouched", 32'(mem[8'h0E]), 32'(8'h0E ^ 8'h5A));
    last_rd = '0;
    do_read(8'h0C, 1'b0);

    // Top of the address space: no wrap.
    do_write(8'hFD, 32'h89ABCDEF);
    do_read(8'hFE, 1'b0);
    chk("top_word", last_rd, 32'h89ABCDEF);

    for (int n = 0; n < 40; n++) begin
      logic [7:0]  a;
      logic [31:0] d;
      int          op;
      a  = 8'($urandom);
      d  = $urandom;
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        do_read(a, 1'b0);
      end else if (op == 1) begin
        do_write(a, d);
      end else begin
        wdata = d;
        do_read(a, 1'b1);
        req_write = 1'b0;
      end
    end
    for (int i = 0; i < 256; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
